xy_seq_monitor: RTL and testbench

//  Synthesizable RTL monitor for the two-cycle sequence "x ##1 y" on posedge clk.

---
 rtl/xy_seq_monitor.sv | 131 +++++++++++++
 tb/tb_xy_seq_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/xy_seq_monitor.sv
// xy_seq_monitor: counts and records every "x ##1 y" match on posedge clk.
// Records go to a small FIFO drained by a valid/ready consumer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   x, y              sequence terms, sampled at posedge clk
//   hit               one-cycle pulse per match (latency 1)
//   hit_cnt           saturating match count since reset
//   rec_valid/ready   record FIFO handshake, rec_data = head record
//   overflow          sticky: a record was dropped on a full FIFO
//
// Build option: define XY_MON_TSTAMP_EN to record the cycle timestamp
// of each match instead of the updated match count.
module xy_seq_monitor #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [TS_W-1:0]  rec_data,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  state_t state, state_nxt;
  logic   match;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ARMED stays armed while x holds, so x=y=1 matches every edge.
  always_comb begin
    state_nxt = state;
    match     = 1'b0;
    unique case (state)
      IDLE:  state_nxt = x ? ARMED : IDLE;
      ARMED: begin
        match     = y;
        state_nxt = x ? ARMED : IDLE;
      end
    endcase
  end

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = hit_cnt;
    if (match && hit_cnt != {CNT_W{1'b1}})
      cnt_nxt = hit_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      hit     <= match;
      hit_cnt <= cnt_nxt;
    end
  end

  logic [TS_W-1:0] pay;

`ifdef XY_MON_TSTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  // Timestamp of the matching edge, before this edge's increment.
  assign pay = ts;
`else
  assign pay = TS_W'(cnt_nxt);
`endif

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [TS_W-1:0] last_q;
  logic            full, pop, push, drop;

  assign rec_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = rec_valid && rec_ready;
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign push      = match && (!full || pop);
  assign drop      = match && full && !pop;

  // Once empty, keep showing the record that was popped last.
  assign rec_data  = rec_valid ? mem[rptr] : last_q;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= pay;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr   <= rptr + AW'(1);
        last_q <= mem[rptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xy_seq_monitor.sv
// tb_xy_seq_monitor: directed checks of xy_seq_monitor (default build,
// payload = updated hit count), plus a CNT_W=3 instance for saturation.
module tb_xy_seq_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x = 1'b0;
  logic        y = 1'b0;
  logic        rec_ready = 1'b0;

  logic        hit;
  logic [15:0] hit_cnt;
  logic        rec_valid;
  logic [15:0] rec_data;
  logic        overflow;

  logic        hit3;
  logic [2:0]  hit_cnt3;
  logic        rec_valid3;
  logic [15:0] rec_data3;
  logic        overflow3;

  int total  = 0;
  int passed = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  xy_seq_monitor dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .hit(hit), .hit_cnt(hit_cnt),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .overflow(overflow)
  );

  xy_seq_monitor #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .hit(hit3), .hit_cnt(hit_cnt3),
    .rec_valid(rec_valid3), .rec_ready(rec_ready),
    .rec_data(rec_data3), .overflow(overflow3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply x/y for one edge, then sample 1 time unit after it.
  task automatic tick(input logic xi, input logic yi);
    x = xi;
    y = yi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rec_ready = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic match_spaced();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #1;
    do_reset();
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_cnt", 32'(hit_cnt), 32'd0);
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_data", 32'(rec_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // T1
    tick(1'b1, 1'b0);
    check("t1_e0_hit", 32'(hit), 32'd0);
    tick(1'b0, 1'b1);
    check("t1_hit", 32'(hit), 32'd1);
    check("t1_cnt", 32'(hit_cnt), 32'd1);
    check("t1_valid", 32'(rec_valid), 32'd1);
    check("t1_data", 32'(rec_data), 32'd1);
    tick(1'b0, 1'b0);
    check("t1_pulse_end", 32'(hit), 32'd0);

    // T2
    do_reset();
    rec_ready = 1'b1;
    tick(1'b1, 1'b1);
    check("t2_e0_hit", 32'(hit), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b1);
      check("t2_hit", 32'(hit), 32'd1);
      check("t2_cnt", 32'(hit_cnt), 32'(i));
      check("t2_data", 32'(rec_data), 32'(i));
    end
    tick(1'b0, 1'b0);
    check("t2_no_hit", 32'(hit), 32'd0);
    check("t2_empty", 32'(rec_valid), 32'd0);
    check("t2_data_hold", 32'(rec_data), 32'd4);

    // T3
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("t3_e1_hit", 32'(hit), 32'd0);
    tick(1'b0, 1'b1);
    check("t3_e2_hit", 32'(hit), 32'd0);
    check("t3_cnt", 32'(hit_cnt), 32'd0);
    check("t3_valid", 32'(rec_valid), 32'd0);

    // T4
    do_reset();
    for (int i = 0; i < 4; i++) match_spaced();
    check("t4_full_ovf", 32'(overflow), 32'd0);
    match_spaced();
    match_spaced();
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_cnt", 32'(hit_cnt), 32'd6);
    check("t4_valid", 32'(rec_valid), 32'd1);
    check("t4_head_held", 32'(rec_data), 32'd1);
    rec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t4_drain_valid", 32'(rec_valid), 32'd1);
      check("t4_drain_data", 32'(rec_data), 32'(i));
      tick(1'b0, 1'b0);
    end
    check("t4_drained", 32'(rec_valid), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    check("t4_data_hold", 32'(rec_data), 32'd4);

    // Push into a full FIFO with a pop on the same edge.
    do_reset();
    for (int i = 0; i < 4; i++) match_spaced();
    tick(1'b1, 1'b0);
    rec_ready = 1'b1;
    tick(1'b0, 1'b1);
    check("t4b_cnt", 32'(hit_cnt), 32'd5);
    check("t4b_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      check("t4b_data", 32'(rec_data), 32'(i));
      tick(1'b0, 1'b0);
    end
    check("t4b_empty", 32'(rec_valid), 32'd0);

    // T5
    do_reset();
    rec_ready = 1'b1;
    pulses = 0;
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b1);
      if (hit3) pulses++;
      if (i == 7) check("t5_cnt7", 32'(hit_cnt3), 32'd7);
    end
    tick(1'b0, 1'b0);
    check("t5_sat", 32'(hit_cnt3), 32'd7);
    check("t5_pulses", 32'(pulses), 32'd10);
    check("t5_wide_cnt", 32'(hit_cnt), 32'd10);

    // T6
    do_reset();
    tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b1);
    rst = 1'b0;
    tick(1'b0, 1'b1);
    check("t6_hit", 32'(hit), 32'd0);
    check("t6_cnt", 32'(hit_cnt), 32'd0);
    check("t6_valid", 32'(rec_valid), 32'd0);
    check("t6_data", 32'(rec_data), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    tick(1'b0, 1'b0);
    check("t6_hit_late", 32'(hit), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
